capture_controller: RTL and testbench

//  Sequences one logic-analyser capture around the SignalAnalyser change-event stream.

---
 rtl/capture_controller.sv | 176 +++++++++++++++++
 tb/tb_capture_controller.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/capture_controller.sv
// Logic-analyser capture sequencer: arms on host request, streams {time,data} change
// events into a ring-buffer RAM, triggers on a masked value/edge match, then stops.
module capture_controller #(
  parameter int DATA_W = 8,
  parameter int TIME_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     arm,
  input  logic                     abort,
  input  logic [DATA_W-1:0]        trig_value,
  input  logic [DATA_W-1:0]        trig_mask,
  input  logic                     trig_edge,
  input  logic [ADDR_W-1:0]        post_count,
  input  logic                     ev_valid,
  input  logic [DATA_W-1:0]        ev_data,
  input  logic [TIME_W-1:0]        ev_time,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_waddr,
  output logic [TIME_W+DATA_W-1:0] mem_wdata,
  output logic                     busy,
  output logic                     triggered,
  output logic                     done,
  output logic                     wrapped,
  output logic [ADDR_W-1:0]        trig_addr,
  output logic [TIME_W-1:0]        trig_time
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_POST  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e                    state_q, state_d;
  logic [DATA_W-1:0]         val_q, val_d;
  logic [DATA_W-1:0]         mask_q, mask_d;
  logic                      edge_q, edge_d;
  logic [ADDR_W-1:0]         post_q, post_d;
  logic [ADDR_W-1:0]         wptr_q, wptr_d;
  logic [ADDR_W-1:0]         remain_q, remain_d;
  logic                      prev_match_q, prev_match_d;
  logic                      wrapped_q, wrapped_d;
  logic                      triggered_q, triggered_d;
  logic [ADDR_W-1:0]         trig_addr_q, trig_addr_d;
  logic [TIME_W-1:0]         trig_time_q, trig_time_d;
  logic                      mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]         mem_waddr_q, mem_waddr_d;
  logic [TIME_W+DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;

  logic capturing;
  logic accept;
  logic match;
  logic hit;

  always_comb begin
    capturing = (state_q == S_ARMED) || (state_q == S_POST);
    // abort in the same cycle as an event suppresses its write
    accept    = ev_valid && capturing && !abort;
    match     = ((ev_data ^ val_q) & mask_q) == '0;
    hit       = accept && (state_q == S_ARMED) &&
                (edge_q ? (match && !prev_match_q) : match);
  end

  always_comb begin
    state_d      = state_q;
    val_d        = val_q;
    mask_d       = mask_q;
    edge_d       = edge_q;
    post_d       = post_q;
    wptr_d       = wptr_q;
    remain_d     = remain_q;
    prev_match_d = prev_match_q;
    wrapped_d    = wrapped_q;
    triggered_d  = triggered_q;
    trig_addr_d  = trig_addr_q;
    trig_time_d  = trig_time_q;
    mem_we_d     = 1'b0;
    mem_waddr_d  = mem_waddr_q;
    mem_wdata_d  = mem_wdata_q;

    if (abort) begin
      state_d     = S_IDLE;
      triggered_d = 1'b0;
    end else if (arm && !capturing) begin
      state_d      = S_ARMED;
      val_d        = trig_value;
      mask_d       = trig_mask;
      edge_d       = trig_edge;
      post_d       = post_count;
      wptr_d       = '0;
      wrapped_d    = 1'b0;
      triggered_d  = 1'b0;
      prev_match_d = 1'b1;
    end else if (accept) begin
      mem_we_d    = 1'b1;
      mem_waddr_d = wptr_q;
      mem_wdata_d = {ev_time, ev_data};
      wptr_d      = wptr_q + 1'b1;
      if (wptr_q == '1) wrapped_d = 1'b1;

      if (state_q == S_ARMED) begin
        prev_match_d = match;
        if (hit) begin
          triggered_d = 1'b1;
          trig_addr_d = wptr_q;
          trig_time_d = ev_time;
          remain_d    = post_q;
          state_d     = (post_q == '0) ? S_DONE : S_POST;
        end
      end else begin
        remain_d = remain_q - 1'b1;
        if (remain_q == ADDR_W'(1)) state_d = S_DONE;
      end
    end

    // status flags are registered from the next state so outputs stay flop-driven
    busy_d = (state_d == S_ARMED) || (state_d == S_POST);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      val_q        <= '0;
      mask_q       <= '0;
      edge_q       <= 1'b0;
      post_q       <= '0;
      wptr_q       <= '0;
      remain_q     <= '0;
      prev_match_q <= 1'b0;
      wrapped_q    <= 1'b0;
      triggered_q  <= 1'b0;
      trig_addr_q  <= '0;
      trig_time_q  <= '0;
      mem_we_q     <= 1'b0;
      mem_waddr_q  <= '0;
      mem_wdata_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      val_q        <= val_d;
      mask_q       <= mask_d;
      edge_q       <= edge_d;
      post_q       <= post_d;
      wptr_q       <= wptr_d;
      remain_q     <= remain_d;
      prev_match_q <= prev_match_d;
      wrapped_q    <= wrapped_d;
      triggered_q  <= triggered_d;
      trig_addr_q  <= trig_addr_d;
      trig_time_q  <= trig_time_d;
      mem_we_q     <= mem_we_d;
      mem_waddr_q  <= mem_waddr_d;
      mem_wdata_q  <= mem_wdata_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_waddr = mem_waddr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign triggered = triggered_q;
  assign done      = done_q;
  assign wrapped   = wrapped_q;
  assign trig_addr = trig_addr_q;
  assign trig_time = trig_time_q;

endmodule

// File: tb/tb_capture_controller.sv
// Bench for capture_controller: vector table, directed corner sequences and a
// randomized run compared against an event-level capture model.
module tb_capture_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        arm = 1'b0, abort = 1'b0, trig_edge = 1'b0, ev_valid = 1'b0;
  logic [7:0]  trig_value = '0, trig_mask = '0, post_count = '0, ev_data = '0;
  logic [31:0] ev_time = '0;

  logic        mem_we, busy, triggered, done, wrapped;
  logic [7:0]  mem_waddr, trig_addr;
  logic [39:0] mem_wdata;
  logic [31:0] trig_time;

  logic        w_mem_we, w_busy, w_triggered, w_done, w_wrapped;
  logic [2:0]  w_mem_waddr, w_trig_addr;
  logic [39:0] w_mem_wdata;
  logic [31:0] w_trig_time;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  capture_controller #(.DATA_W(8), .TIME_W(32), .ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .arm(arm), .abort(abort),
    .trig_value(trig_value), .trig_mask(trig_mask), .trig_edge(trig_edge),
    .post_count(post_count), .ev_valid(ev_valid), .ev_data(ev_data), .ev_time(ev_time),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .busy(busy), .triggered(triggered), .done(done), .wrapped(wrapped),
    .trig_addr(trig_addr), .trig_time(trig_time));

  capture_controller #(.DATA_W(8), .TIME_W(32), .ADDR_W(3)) dut_w (
    .clk(clk), .rst(rst), .arm(arm), .abort(abort),
    .trig_value(trig_value), .trig_mask(trig_mask), .trig_edge(trig_edge),
    .post_count(post_count[2:0]), .ev_valid(ev_valid), .ev_data(ev_data), .ev_time(ev_time),
    .mem_we(w_mem_we), .mem_waddr(w_mem_waddr), .mem_wdata(w_mem_wdata),
    .busy(w_busy), .triggered(w_triggered), .done(w_done), .wrapped(w_wrapped),
    .trig_addr(w_trig_addr), .trig_time(w_trig_time));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- event-level reference model (depth 256) ----------------
  bit       m_capturing, m_after_trig, m_finished, m_trig, m_wrapped, m_prev;
  int       m_left, m_wp, m_taddr;
  bit [31:0] m_ttime;
  bit [7:0] c_val, c_mask;
  bit       c_edge;
  int       c_post;
  bit       m_we;
  int       m_waddr;
  bit [39:0] m_wdata;

  task automatic model_reset();
    m_capturing = 0; m_after_trig = 0; m_finished = 0; m_trig = 0; m_wrapped = 0;
    m_prev = 0; m_left = 0; m_wp = 0; m_taddr = 0; m_ttime = 0;
    c_val = 0; c_mask = 0; c_edge = 0; c_post = 0;
    m_we = 0; m_waddr = 0; m_wdata = 0;
  endtask

  task automatic model_update();
    bit is_match, fire;
    m_we = 0;
    if (abort) begin
      m_capturing = 0; m_finished = 0; m_trig = 0;
    end else if (arm && !m_capturing) begin
      c_val = trig_value; c_mask = trig_mask; c_edge = trig_edge; c_post = int'(post_count);
      m_wp = 0; m_wrapped = 0; m_trig = 0; m_prev = 1;
      m_capturing = 1; m_after_trig = 0; m_finished = 0;
    end else if (ev_valid && m_capturing) begin
      m_we = 1; m_waddr = m_wp; m_wdata = {ev_time, ev_data};
      if (!m_after_trig) begin
        is_match = ((ev_data & c_mask) == (c_val & c_mask));
        fire = c_edge ? (is_match && !m_prev) : is_match;
        m_prev = is_match;
        if (fire) begin
          m_trig = 1; m_taddr = m_wp; m_ttime = ev_time;
          if (c_post == 0) begin m_capturing = 0; m_finished = 1; end
          else begin m_after_trig = 1; m_left = c_post; end
        end
      end else begin
        m_left--;
        if (m_left == 0) begin m_capturing = 0; m_finished = 1; end
      end
      if (m_wp == 255) m_wrapped = 1;
      m_wp = (m_wp + 1) % 256;
    end
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic event_step(input logic [7:0] d, input logic [31:0] t);
    ev_valid = 1; ev_data = d; ev_time = t;
    step();
    ev_valid = 0;
  endtask

  task automatic arm_step();
    arm = 1; step(); arm = 0;
  endtask

  // ---------------- vector table: level trigger ----------------
  typedef struct {
    logic       arm;
    logic       ev;
    logic [7:0] d;
    logic [31:0] t;
    logic       we;
    logic [7:0] addr;
    logic       busy;
    logic       done;
    logic       trig;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{1'b1, 1'b0, 8'h00, 32'd0,  1'b0, 8'd0, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 8'h01, 32'd10, 1'b1, 8'd0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 8'h02, 32'd11, 1'b1, 8'd1, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 8'h45, 32'd12, 1'b1, 8'd2, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 8'h03, 32'd13, 1'b1, 8'd3, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 1'b1, 8'h04, 32'd14, 1'b1, 8'd4, 1'b0, 1'b1, 1'b1};
    vecs[6] = '{1'b0, 1'b1, 8'h05, 32'd15, 1'b0, 8'd4, 1'b0, 1'b1, 1'b1};

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0); chk("reset_done", done, 0); chk("reset_we", mem_we, 0);
    chk("reset_trig", triggered, 0); chk("reset_taddr", trig_addr, 0);
    rst = 1;
    step();

    // level trigger table
    trig_value = 8'h45; trig_mask = 8'hFF; trig_edge = 0; post_count = 8'd2;
    for (int unsigned i = 0; i < 7; i++) begin
      arm = vecs[i].arm; ev_valid = vecs[i].ev; ev_data = vecs[i].d; ev_time = vecs[i].t;
      step();
      arm = 0; ev_valid = 0;
      chk($sformatf("lvl_we[%0d]", i), mem_we, vecs[i].we);
      if (vecs[i].we) begin
        chk($sformatf("lvl_addr[%0d]", i), mem_waddr, vecs[i].addr);
        chk($sformatf("lvl_data[%0d]", i), mem_wdata, {vecs[i].t, vecs[i].d});
      end
      chk($sformatf("lvl_busy[%0d]", i), busy, vecs[i].busy);
      chk($sformatf("lvl_done[%0d]", i), done, vecs[i].done);
      chk($sformatf("lvl_trig[%0d]", i), triggered, vecs[i].trig);
    end
    chk("lvl_taddr", trig_addr, 2); chk("lvl_ttime", trig_time, 12);

    // edge trigger, re-armed from DONE so addressing restarts at 0
    trig_edge = 1; trig_mask = 8'h01; trig_value = 8'h01; post_count = 0;
    arm_step();
    event_step(8'h01, 20);
    chk("edge_first_addr", mem_waddr, 0);
    event_step(8'h01, 21);
    event_step(8'h00, 22);
    chk("edge_no_trig", triggered, 0);
    event_step(8'h01, 23);
    chk("edge_trig", triggered, 1); chk("edge_done", done, 1);
    chk("edge_taddr", trig_addr, 3); chk("edge_waddr", mem_waddr, 3);
    chk("edge_ttime", trig_time, 23);

    // config latched at arm; later input changes ignored
    trig_edge = 0; trig_mask = 8'hFF; trig_value = 8'h33; post_count = 1;
    arm_step();
    trig_value = 8'h44; post_count = 5;
    event_step(8'h44, 30);
    chk("cfg_no_trig", triggered, 0);
    event_step(8'h33, 31);
    event_step(8'h55, 32);
    chk("cfg_done", done, 1); chk("cfg_taddr", trig_addr, 1);

    // abort in POST
    trig_value = 8'h77; post_count = 5;
    arm_step();
    event_step(8'h77, 40);
    event_step(8'h01, 41);
    chk("abt_busy_pre", busy, 1); chk("abt_we_pre", mem_we, 1);
    abort = 1; ev_valid = 1; ev_data = 8'h02; ev_time = 42;
    step();
    abort = 0; ev_valid = 0;
    chk("abt_busy", busy, 0); chk("abt_trig", triggered, 0);
    chk("abt_we", mem_we, 0); chk("abt_done", done, 0); chk("abt_taddr", trig_addr, 0);
    event_step(8'h77, 43);
    chk("abt_we_after", mem_we, 0);
    arm = 1; abort = 1; step(); arm = 0; abort = 0;
    chk("armabt_busy", busy, 0);
    event_step(8'h77, 44);
    chk("armabt_we", mem_we, 0);

    // wrap on the 3-bit instance: 10 misses then the trigger at addr 2
    trig_value = 8'hAA; trig_mask = 8'hFF; trig_edge = 0; post_count = 1;
    arm_step();
    for (int unsigned i = 0; i < 10; i++) event_step(8'(i), 32'(50 + i));
    chk("wrap_flag", w_wrapped, 1);
    event_step(8'hAA, 60);
    chk("wrap_taddr", w_trig_addr, 2);
    event_step(8'h11, 61);
    chk("wrap_we", w_mem_we, 1); chk("wrap_waddr", w_mem_waddr, 3);
    chk("wrap_done", w_done, 1); chk("wrap_big_taddr", trig_addr, 10);

    // async reset mid-capture
    trig_value = 8'hEE; post_count = 3;
    arm_step();
    ev_valid = 1; ev_data = 8'h01; ev_time = 70;
    #3 rst = 0;
    model_reset();
    #1;
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_we", mem_we, 0);
    @(posedge clk); #1;
    rst = 1;
    step();
    chk("rst_ign_we", mem_we, 0);
    ev_valid = 0;

    // randomized run against the model
    for (int unsigned cyc = 0; cyc < 4000; cyc++) begin
      arm        = ($urandom_range(0, 19) == 0);
      abort      = ($urandom_range(0, 99) == 0);
      ev_valid   = $urandom_range(0, 1);
      ev_data    = 8'($urandom_range(0, 3));
      ev_time    = $urandom;
      trig_value = 8'($urandom_range(0, 3));
      trig_mask  = 8'($urandom);
      trig_edge  = $urandom_range(0, 1);
      post_count = 8'($urandom_range(0, 6));
      step();
      chk("rnd_we", mem_we, m_we);
      if (m_we) begin
        chk("rnd_waddr", mem_waddr, m_waddr);
        chk("rnd_wdata", mem_wdata, m_wdata);
      end
      chk("rnd_busy", busy, m_capturing);
      chk("rnd_done", done, m_finished);
      chk("rnd_trig", triggered, m_trig);
      chk("rnd_wrapped", wrapped, m_wrapped);
      chk("rnd_taddr", trig_addr, m_taddr);
      chk("rnd_ttime", trig_time, m_ttime);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
